srv_mem_arb: RTL

SRV_MEM_ARB -- requirements
Module: srv_mem_arb

---
 rtl/srv_mem_pkg.sv | 22 ++
 rtl/srv_mem_arb_if.sv | 20 ++
 rtl/srv_mem_arb_rr.sv | 18 +
 rtl/srv_mem_arb.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/srv_mem_pkg.sv
// Shared types and widths for the two-port memory arbiter.
package srv_mem_pkg;
   localparam int LINE_W = 128;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_e;

   typedef enum logic {
      PORT_IC = 1'b0,
      PORT_DP = 1'b1
   } port_e;

   function automatic logic [DATA_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                   input logic [1:0] sel);
      return line[DATA_W*sel +: DATA_W];
   endfunction
endpackage

// File: rtl/srv_mem_arb_if.sv
// External memory bus: the arbiter is the master, the memory is the slave.
interface srv_mem_arb_if;
   logic                            mem_req_o;
   logic [srv_mem_pkg::ADDR_W-1:0]  mem_addr_o;
   logic                            mem_we_o;
   logic [srv_mem_pkg::DATA_W-1:0]  mem_wdata_o;
   logic                            mem_gnt_i;
   logic                            mem_rsp_i;
   logic [srv_mem_pkg::LINE_W-1:0]  mem_rdata_i;

   modport master (
      output mem_req_o, mem_addr_o, mem_we_o, mem_wdata_o,
      input  mem_gnt_i, mem_rsp_i, mem_rdata_i
   );

   modport slave (
      input  mem_req_o, mem_addr_o, mem_we_o, mem_wdata_o,
      output mem_gnt_i, mem_rsp_i, mem_rdata_i
   );
endinterface

// File: rtl/srv_mem_arb_rr.sv
// Two-way round-robin pick: bit 0 = instruction port, bit 1 = data port.
module srv_rr_arb2
   import srv_mem_pkg::*;
(
   input  logic [1:0] req_i,
   input  port_e      last_gnt_i,
   output logic [1:0] gnt_o
);
   always_comb begin
      gnt_o = 2'b00;
      case (req_i)
         2'b01:   gnt_o = 2'b01;
         2'b10:   gnt_o = 2'b10;
         2'b11:   gnt_o = (last_gnt_i == PORT_DP) ? 2'b01 : 2'b10;
         default: gnt_o = 2'b00;
      endcase
   end
endmodule

// File: rtl/srv_mem_arb.sv
// Arbitrates I-cache refills and data accesses onto one memory port.
// Optional WAIT timeout abort is enabled by defining SRV_MEM_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no transaction, pick a winner from pending/new requests
// REQ   | mem_req_o held with winner's fields until mem_gnt_i
// WAIT  | granted, waiting for mem_rsp_i (or timeout)
module srv_mem_arb
   import srv_mem_pkg::*;
#(
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ic_req_i,
   input  logic [ADDR_W-1:0] ic_addr_i,
   output logic              ic_rsp_o,
   output logic [LINE_W-1:0] ic_data_o,
   input  logic              dp_req_i,
   input  logic              dp_we_i,
   input  logic [ADDR_W-1:0] dp_addr_i,
   input  logic [DATA_W-1:0] dp_wdata_i,
   output logic              dp_rsp_o,
   output logic [DATA_W-1:0] dp_rdata_o,
   srv_mem_arb_if.master     mem,
   output logic              err_o
);
   if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
      $error("TIMEOUT_CYC must be within 1..65535");
   end

   state_e            state_q, state_d;
   port_e             last_gnt_q, last_gnt_d;
   port_e             win_q, win_d;
   logic              ic_pend_q, ic_pend_d;
   logic [ADDR_W-1:0] ic_addr_q, ic_addr_d;
   logic              dp_pend_q, dp_pend_d;
   logic              dp_we_q, dp_we_d;
   logic [ADDR_W-1:0] dp_addr_q, dp_addr_d;
   logic [DATA_W-1:0] dp_wdata_q, dp_wdata_d;
   logic              mem_req_q, mem_req_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              mem_we_q, mem_we_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

   logic              rsp_hit, to_hit, done, data_ok;
   logic [1:0]        gnt;
   logic              ic_pend_eff, dp_pend_eff;
   logic [ADDR_W-1:0] ic_addr_eff, dp_addr_eff;
   logic              dp_we_eff;
   logic [DATA_W-1:0] dp_wdata_eff;

`ifdef SRV_MEM_ARB_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYC > 255) ? 16 : 8;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   assign to_hit = (state_q == WAIT) && !mem.mem_rsp_i &&
                   (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
   assign to_hit = 1'b0;
`endif

   // A request pulse seen in IDLE competes in the same cycle it arrives.
   assign ic_pend_eff  = ic_pend_q | ic_req_i;
   assign dp_pend_eff  = dp_pend_q | dp_req_i;
   assign ic_addr_eff  = ic_pend_q ? ic_addr_q  : ic_addr_i;
   assign dp_addr_eff  = dp_pend_q ? dp_addr_q  : dp_addr_i;
   assign dp_we_eff    = dp_pend_q ? dp_we_q    : dp_we_i;
   assign dp_wdata_eff = dp_pend_q ? dp_wdata_q : dp_wdata_i;

   srv_rr_arb2 u_rr (
      .req_i      ({dp_pend_eff, ic_pend_eff}),
      .last_gnt_i (last_gnt_q),
      .gnt_o      (gnt)
   );

   assign rsp_hit = (state_q == WAIT) && mem.mem_rsp_i;
   assign done    = rsp_hit | to_hit;

   always_comb begin
      state_d     = state_q;
      last_gnt_d  = last_gnt_q;
      win_d       = win_q;
      ic_pend_d   = ic_pend_q;
      ic_addr_d   = ic_addr_q;
      dp_pend_d   = dp_pend_q;
      dp_we_d     = dp_we_q;
      dp_addr_d   = dp_addr_q;
      dp_wdata_d  = dp_wdata_q;
      mem_req_d   = mem_req_q;
      mem_addr_d  = mem_addr_q;
      mem_we_d    = mem_we_q;
      mem_wdata_d = mem_wdata_q;
`ifdef SRV_MEM_ARB_TIMEOUT_EN
      cnt_d       = cnt_q;
`endif

      if (ic_req_i && !ic_pend_q) begin
         ic_pend_d = 1'b1;
         ic_addr_d = ic_addr_i;
      end
      if (dp_req_i && !dp_pend_q) begin
         dp_pend_d  = 1'b1;
         dp_we_d    = dp_we_i;
         dp_addr_d  = dp_addr_i;
         dp_wdata_d = dp_wdata_i;
      end

      case (state_q)
         IDLE: begin
            if (ic_pend_eff || dp_pend_eff) begin
               state_d     = REQ;
               win_d       = gnt[1] ? PORT_DP : PORT_IC;
               mem_req_d   = 1'b1;
               mem_addr_d  = gnt[1] ? dp_addr_eff : ic_addr_eff;
               mem_we_d    = gnt[1] & dp_we_eff;
               mem_wdata_d = gnt[1] ? dp_wdata_eff : '0;
            end
         end
         REQ: begin
            if (mem.mem_gnt_i) begin
               state_d   = WAIT;
               mem_req_d = 1'b0;
`ifdef SRV_MEM_ARB_TIMEOUT_EN
               cnt_d     = '0;
`endif
            end
         end
         WAIT: begin
`ifdef SRV_MEM_ARB_TIMEOUT_EN
            cnt_d = cnt_q + 1'b1;
`endif
            if (done) begin
               state_d    = IDLE;
               last_gnt_d = win_q;
               if (win_q == PORT_IC) ic_pend_d = 1'b0;
               else                  dp_pend_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         last_gnt_q  <= PORT_DP;
         win_q       <= PORT_IC;
         ic_pend_q   <= 1'b0;
         ic_addr_q   <= '0;
         dp_pend_q   <= 1'b0;
         dp_we_q     <= 1'b0;
         dp_addr_q   <= '0;
         dp_wdata_q  <= '0;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= '0;
         mem_we_q    <= 1'b0;
         mem_wdata_q <= '0;
`ifdef SRV_MEM_ARB_TIMEOUT_EN
         cnt_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         last_gnt_q  <= last_gnt_d;
         win_q       <= win_d;
         ic_pend_q   <= ic_pend_d;
         ic_addr_q   <= ic_addr_d;
         dp_pend_q   <= dp_pend_d;
         dp_we_q     <= dp_we_d;
         dp_addr_q   <= dp_addr_d;
         dp_wdata_q  <= dp_wdata_d;
         mem_req_q   <= mem_req_d;
         mem_addr_q  <= mem_addr_d;
         mem_we_q    <= mem_we_d;
         mem_wdata_q <= mem_wdata_d;
`ifdef SRV_MEM_ARB_TIMEOUT_EN
         cnt_q       <= cnt_d;
`endif
      end
   end

   assign mem.mem_req_o   = mem_req_q;
   assign mem.mem_addr_o  = mem_addr_q;
   assign mem.mem_we_o    = mem_we_q;
   assign mem.mem_wdata_o = mem_wdata_q;

   // Read data is pass-through; zeroed under reset and on a timeout abort.
   assign data_ok    = !rst && !to_hit;
   assign ic_rsp_o   = done && (win_q == PORT_IC);
   assign dp_rsp_o   = done && (win_q == PORT_DP);
   assign ic_data_o  = data_ok ? mem.mem_rdata_i : '0;
   assign dp_rdata_o = data_ok ? line_word(mem.mem_rdata_i, dp_addr_q[3:2]) : '0;
   assign err_o      = to_hit;
endmodule
